up_phase_sequencer: RTL and testbench

//   Control unit for the 4-bit uP datapath (PC, program ROM, ACCU, ALU, RAM, I/O buses).

---
 rtl/up_pkg.sv | 52 +++++
 rtl/up_phase_sequencer_if.sv | 28 ++
 rtl/up_decode_rom.sv | 72 +++++++
 rtl/up_phase_sequencer.sv | 96 +++++++++
 tb/tb_up_phase_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/up_pkg.sv
// Shared types and constants for the 4-bit uP control unit: phase states,
// opcodes, ALU select codes and control-word bit positions.
package up_pkg;

  localparam int CTRL_W = 13;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [2:0] ALU_NONE   = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  localparam int CB_INC_PC     = 12;
  localparam int CB_LOAD_PC    = 11;
  localparam int CB_LOAD_A     = 10;
  localparam int CB_LOAD_FLAGS = 9;
  localparam int CB_ALU_HI     = 8;
  localparam int CB_ALU_LO     = 6;
  localparam int CB_CS_RAM     = 5;
  localparam int CB_WE_RAM     = 4;
  localparam int CB_OE_ALU     = 3;
  localparam int CB_OE_IN      = 2;
  localparam int CB_OE_OPRND   = 1;
  localparam int CB_LOAD_OUT   = 0;

  localparam logic [CTRL_W-1:0] CTRL_FETCH = 13'h1000;
  localparam logic [CTRL_W-1:0] CTRL_HALT  = 13'h0000;

endpackage

// File: rtl/up_phase_sequencer_if.sv
// Bundles the sequencer's datapath-facing signals; slave = sequencer side.
interface up_phase_sequencer_if #(
  parameter int RETIRE_W = 16
);
  import up_pkg::*;

  logic [3:0]          instr;
  logic                alu_c;
  logic                alu_z;
  logic                halt_req;
  logic                step;
  logic [CTRL_W-1:0]   ctrl;
  logic                phase;
  logic                c_flag;
  logic                z_flag;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport slave (
    input  instr, alu_c, alu_z, halt_req, step,
    output ctrl, phase, c_flag, z_flag, halted, retired
  );

  modport master (
    output instr, alu_c, alu_z, halt_req, step,
    input  ctrl, phase, c_flag, z_flag, halted, retired
  );
endinterface

// File: rtl/up_decode_rom.sv
// Pure combinational decode of {phase, C, Z, instr} into the 13-bit control
// word; written as a lookup so it can later be replaced by a ROM image.
module up_decode_rom
  import up_pkg::*;
(
  input  logic              phase,
  input  logic              c_flag,
  input  logic              z_flag,
  input  logic [3:0]        instr,
  output logic [CTRL_W-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    if (!phase) begin
      ctrl = CTRL_FETCH;
    end else begin
      case (instr)
        // Untaken conditional jumps still step PC past the address byte.
        OP_JC:  begin ctrl[CB_LOAD_PC] = c_flag;  ctrl[CB_INC_PC] = ~c_flag; end
        OP_JNC: begin ctrl[CB_LOAD_PC] = ~c_flag; ctrl[CB_INC_PC] = c_flag;  end
        OP_JZ:  begin ctrl[CB_LOAD_PC] = z_flag;  ctrl[CB_INC_PC] = ~z_flag; end
        OP_JNZ: begin ctrl[CB_LOAD_PC] = ~z_flag; ctrl[CB_INC_PC] = z_flag;  end
        OP_JMP: ctrl[CB_LOAD_PC] = 1'b1;
        OP_CMPI: begin
          ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_SUB;
          ctrl[CB_OE_OPRND]   = 1'b1;
          ctrl[CB_LOAD_FLAGS] = 1'b1;
        end
        OP_CMPM: begin
          ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_SUB;
          ctrl[CB_CS_RAM]     = 1'b1;
          ctrl[CB_LOAD_FLAGS] = 1'b1;
          ctrl[CB_INC_PC]     = 1'b1;
        end
        OP_LIT, OP_ADDI, OP_NANDI: begin
          ctrl[CB_ALU_HI:CB_ALU_LO] = (instr == OP_LIT)  ? ALU_PASS_B :
                                      (instr == OP_ADDI) ? ALU_ADD : ALU_NAND;
          ctrl[CB_OE_OPRND]   = 1'b1;
          ctrl[CB_LOAD_A]     = 1'b1;
          ctrl[CB_LOAD_FLAGS] = 1'b1;
        end
        OP_IN: begin
          ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_PASS_B;
          ctrl[CB_OE_IN]      = 1'b1;
          ctrl[CB_LOAD_A]     = 1'b1;
          ctrl[CB_LOAD_FLAGS] = 1'b1;
        end
        OP_LD, OP_ADDM, OP_NANDM: begin
          ctrl[CB_ALU_HI:CB_ALU_LO] = (instr == OP_LD)   ? ALU_PASS_B :
                                      (instr == OP_ADDM) ? ALU_ADD : ALU_NAND;
          ctrl[CB_CS_RAM]     = 1'b1;
          ctrl[CB_LOAD_A]     = 1'b1;
          ctrl[CB_LOAD_FLAGS] = 1'b1;
          ctrl[CB_INC_PC]     = 1'b1;
        end
        OP_ST: begin
          ctrl[CB_CS_RAM] = 1'b1;
          ctrl[CB_WE_RAM] = 1'b1;
          ctrl[CB_OE_ALU] = 1'b1;
          ctrl[CB_INC_PC] = 1'b1;
        end
        OP_OUT: begin
          ctrl[CB_OE_ALU]   = 1'b1;
          ctrl[CB_LOAD_OUT] = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/up_phase_sequencer.sv
// FETCH/EXEC/HALT phase machine, C/Z flag register and retire counter.
// Optional build macro SINGLE_STEP_EN: halt after every instruction, resume on step edge.
module up_phase_sequencer
  import up_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic clock,
  input  logic reset,
  up_phase_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic                phase_q, phase_d;
  logic                halted_q, halted_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [CTRL_W-1:0]   rom_ctrl;
  logic                resume;

  up_decode_rom u_decode (
    .phase  (phase_q),
    .c_flag (c_q),
    .z_flag (z_q),
    .instr  (bus.instr),
    .ctrl   (rom_ctrl)
  );

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= bus.step;
  end

  // Only a fresh rising edge of step releases HALT, so a held step runs one instruction.
  assign resume = bus.step & ~step_q & ~bus.halt_req;
`else
  assign resume = ~bus.halt_req;
`endif

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    z_d       = z_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (rom_ctrl[CB_LOAD_FLAGS]) begin
          c_d = bus.alu_c;
          z_d = bus.alu_z;
        end
        retired_d = retired_q + RETIRE_W'(1);
`ifdef SINGLE_STEP_EN
        state_d = ST_HALT;
`else
        state_d = bus.halt_req ? ST_HALT : ST_FETCH;
`endif
      end
      ST_HALT: state_d = resume ? ST_FETCH : ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    phase_d  = (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      phase_q   <= 1'b0;
      halted_q  <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      halted_q  <= halted_d;
      c_q       <= c_d;
      z_q       <= z_d;
      retired_q <= retired_d;
    end
  end

  // HALT shares phase=0 with FETCH, so the frozen word is forced here.
  assign bus.ctrl    = halted_q ? CTRL_HALT : rom_ctrl;
  assign bus.phase   = phase_q;
  assign bus.halted  = halted_q;
  assign bus.c_flag  = c_q;
  assign bus.z_flag  = z_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_up_phase_sequencer.sv
// Randomized scoreboard bench for up_phase_sequencer against an opcode-table model.
module tb_up_phase_sequencer;

  localparam int RW   = 8;     // narrow counter so the wrap boundary is reached quickly
  localparam int NCYC = 3000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  up_phase_sequencer_if #(.RETIRE_W(RW)) bus ();

  up_phase_sequencer #(.RETIRE_W(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [12:0] ctrl;
    logic        phase;
    logic        c;
    logic        z;
    logic        halted;
    logic [RW-1:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: 0=FETCH 1=EXEC 2=HALT
  int          m_st;
  logic        m_c, m_z, m_prev_step;
  int unsigned m_ret;

  function automatic logic [12:0] exec_word(input logic [3:0] op, input logic c, input logic z);
    case (op)
      4'h0: return c  ? 13'h0800 : 13'h1000;
      4'h1: return !c ? 13'h0800 : 13'h1000;
      4'h8: return z  ? 13'h0800 : 13'h1000;
      4'h9: return !z ? 13'h0800 : 13'h1000;
      4'hC: return 13'h0800;
      4'h2: return 13'h0242;
      4'h3: return 13'h1260;
      4'h4: return 13'h0682;
      4'h5: return 13'h0684;
      4'h6: return 13'h16A0;
      4'h7: return 13'h1038;
      4'hA: return 13'h06C2;
      4'hB: return 13'h16E0;
      4'hD: return 13'h0009;
      4'hE: return 13'h0702;
      default: return 13'h1720;
    endcase
  endfunction

  function automatic logic op_sets_flags(input logic [3:0] op);
    return op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hE, 4'hF};
  endfunction

  task automatic model_reset();
    m_st = 0; m_c = 1'b0; m_z = 1'b0; m_ret = 0; m_prev_step = 1'b0;
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Stimulus and model: one new input vector per cycle, expected outputs queued.
  initial begin
    exp_t e;
    bus.instr = 4'h4; bus.alu_c = 1'b0; bus.alu_z = 1'b0;
    bus.halt_req = 1'b0; bus.step = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clock);
      #1;
      reset = (cyc < 2) || ($urandom_range(0, 199) == 0);
      bus.instr = 4'($urandom_range(0, 15));
      bus.alu_c = 1'($urandom_range(0, 1));
      bus.alu_z = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.halt_req = ~bus.halt_req;
      if ($urandom_range(0, 2) == 0) bus.step = ~bus.step;
      if (reset) model_reset();

      e.cyc     = cyc;
      e.phase   = (m_st == 1);
      e.halted  = (m_st == 2);
      e.c       = m_c;
      e.z       = m_z;
      e.retired = RW'(m_ret);
      e.ctrl    = (m_st == 0) ? 13'h1000 : (m_st == 2) ? 13'h0000 : exec_word(bus.instr, m_c, m_z);
      exp_q.push_back(e);

      if (!reset) begin
        case (m_st)
          0: m_st = 1;
          1: begin
            if (op_sets_flags(bus.instr)) begin m_c = bus.alu_c; m_z = bus.alu_z; end
            m_ret = (m_ret + 1) % (1 << RW);
`ifdef SINGLE_STEP_EN
            m_st = 2;
`else
            m_st = bus.halt_req ? 2 : 0;
`endif
          end
          default: begin
`ifdef SINGLE_STEP_EN
            if (bus.step && !m_prev_step && !bus.halt_req) m_st = 0;
`else
            if (!bus.halt_req) m_st = 0;
`endif
          end
        endcase
        m_prev_step = bus.step;
      end
    end
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 pending entries", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl",    e.cyc, 32'(bus.ctrl),    32'(e.ctrl));
        chk("phase",   e.cyc, 32'(bus.phase),   32'(e.phase));
        chk("halted",  e.cyc, 32'(bus.halted),  32'(e.halted));
        chk("c_flag",  e.cyc, 32'(bus.c_flag),  32'(e.c));
        chk("z_flag",  e.cyc, 32'(bus.z_flag),  32'(e.z));
        chk("retired", e.cyc, 32'(bus.retired), 32'(e.retired));
      end
    end
  end

endmodule
